// File: rtl/matrix_loader.sv
// Assembles matrix A (row-major) and matrix B (column-major) from a dibit stream.
// After loading, it serves one A row and one B column per cycle with a registered read.
module matrix_loader #(
   parameter int N_VEC       = 32,
   parameter int VEC_W       = 256,
   parameter int DIB_PER_VEC = VEC_W / 2
) (
   input  logic             ether_refclk,
   input  logic             rst,
   input  logic             axiiv,
   input  logic [1:0]       axiid,
   input  logic [4:0]       requested_a_row,
   input  logic [4:0]       requested_b_col,
   output logic [4:0]       addr_out,
   output logic [VEC_W-1:0] a_row_out,
   output logic [VEC_W-1:0] b_col_out,
   output logic             complete
);

   localparam logic [12:0] LAST_DIBIT = 13'h1FFF;
   localparam logic [6:0]  LAST_IN_VEC = 7'(DIB_PER_VEC - 1);

   logic [12:0]      cnt_q, cnt_d;
   logic [VEC_W-3:0] sr_q, sr_d;
   logic             complete_q, complete_d;

   logic             accept;
   logic             vecDone;
   logic             isB;
   logic [4:0]       vecIdx;
   logic [VEC_W-1:0] vecFull;

   logic [VEC_W-1:0] aMem_q [N_VEC];
   logic [VEC_W-1:0] bMem_q [N_VEC];

   // After the last dibit, the counter freezes at 8191 and the stream is ignored until reset.
   always_comb begin
      accept     = axiiv && !complete_q;
      vecFull    = {sr_q, axiid};
      vecIdx     = cnt_q[11:7];
      isB        = cnt_q[12];
      vecDone    = accept && (cnt_q[6:0] == LAST_IN_VEC);
      cnt_d      = cnt_q;
      sr_d       = sr_q;
      complete_d = complete_q;
      if (accept) begin
         sr_d = vecFull[VEC_W-3:0];
         if (cnt_q == LAST_DIBIT) begin
            complete_d = 1'b1;
         end else begin
            cnt_d = cnt_q + 13'd1;
         end
      end
   end

   always_ff @(posedge ether_refclk) begin
      if (rst) begin
         cnt_q      <= '0;
         sr_q       <= '0;
         complete_q <= 1'b0;
         addr_out   <= '0;
         a_row_out  <= '0;
         b_col_out  <= '0;
      end else begin
         cnt_q      <= cnt_d;
         sr_q       <= sr_d;
         complete_q <= complete_d;
         addr_out   <= requested_a_row;
         a_row_out  <= aMem_q[requested_a_row];
         b_col_out  <= bMem_q[requested_b_col];
      end
   end

   // Storage is never cleared. A read of the vector being written in the same cycle sees the old contents.
   always_ff @(posedge ether_refclk) begin
      if (!rst && vecDone) begin
         if (isB) begin
            bMem_q[vecIdx] <= vecFull;
         end else begin
            aMem_q[vecIdx] <= vecFull;
         end
      end
   end

   assign complete = complete_q;

endmodule

// File: tb/tb_matrix_loader.sv
// Directed self-checking bench for matrix_loader.
// It covers reset, full load, bit order, stream gaps, overrun and reset during a load.
module tb_matrix_loader;

   logic         ether_refclk = 1'b0;
   logic         rst = 1'b0;
   logic         axiiv = 1'b0;
   logic [1:0]   axiid = 2'b00;
   logic [4:0]   requested_a_row = '0;
   logic [4:0]   requested_b_col = '0;
   logic [4:0]   addr_out;
   logic [255:0] a_row_out;
   logic [255:0] b_col_out;
   logic         complete;

   int testsRun = 0;
   int testsFailed = 0;
   int gapCtr = 0;

   matrix_loader dut (
      .ether_refclk(ether_refclk),
      .rst(rst),
      .axiiv(axiiv),
      .axiid(axiid),
      .requested_a_row(requested_a_row),
      .requested_b_col(requested_b_col),
      .addr_out(addr_out),
      .a_row_out(a_row_out),
      .b_col_out(b_col_out),
      .complete(complete)
   );

   always #5 ether_refclk = ~ether_refclk;

   // Pattern 0 is the reference stimulus. Pattern 1 is a distinct pattern used for reloads.
   function automatic logic [255:0] aRow(input int i, input bit pat);
      logic [7:0] b;
      b = pat ? 8'(8'h40 + i) : 8'(i);
      return {32{b}};
   endfunction

   function automatic logic [255:0] bCol(input int j, input bit pat);
      logic [7:0] b;
      if (pat)        b = 8'(8'h80 + j);
      else if (j < 16) b = 8'hF0 | 8'(j);
      else            b = 8'(j);
      return {32{b}};
   endfunction

   task automatic checkOutput(input string tag, input logic [255:0] observed, input logic [255:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic idle(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge ether_refclk);
         axiiv = 1'b0;
      end
   endtask

   task automatic applyStimulus(input logic [1:0] d, input bit gaps);
      if (gaps) begin
         gapCtr++;
         if (gapCtr % 3 == 0) idle(1);
      end
      @(negedge ether_refclk);
      axiiv = 1'b1;
      axiid = d;
   endtask

   task automatic doReset();
      @(negedge ether_refclk);
      axiiv = 1'b0;
      rst = 1'b1;
      idle(2);
      checkOutput("rst_addr", 256'(addr_out), 256'd0);
      checkOutput("rst_arow", a_row_out, 256'd0);
      checkOutput("rst_bcol", b_col_out, 256'd0);
      checkOutput("rst_complete", 256'(complete), 256'd0);
      rst = 1'b0;
   endtask

   // Streams the first nDibits of a full load. When the load is full, complete is checked around the final edge.
   task automatic loadAll(input bit pat, input bit gaps, input int nDibits);
      logic [255:0] v;
      for (int idx = 0; idx < nDibits; idx++) begin
         v = (idx < 4096) ? aRow(idx / 128, pat) : bCol((idx - 4096) / 128, pat);
         if (gaps && idx == 1000) idle(100);
         applyStimulus(v[255 - 2 * (idx % 128) -: 2], gaps);
         if (idx == 8191) checkOutput("complete_before_last", 256'(complete), 256'd0);
      end
      idle(1);
      if (nDibits == 8192) checkOutput("complete_after_last", 256'(complete), 256'd1);
   endtask

   task automatic readCheck(input string tag, input int row, input int col,
                            input logic [255:0] expA, input logic [255:0] expB);
      @(negedge ether_refclk);
      requested_a_row = 5'(row);
      requested_b_col = 5'(col);
      @(negedge ether_refclk);
      checkOutput({tag, "_arow"}, a_row_out, expA);
      checkOutput({tag, "_bcol"}, b_col_out, expB);
      checkOutput({tag, "_addr"}, 256'(addr_out), 256'(row));
   endtask

   task automatic checkAll(input string tag, input bit pat);
      for (int i = 0; i < 32; i++) begin
         readCheck($sformatf("%s_%0d", tag, i), i, i, aRow(i, pat), bCol(i, pat));
      end
   endtask

   initial begin
      logic [255:0] bitVec;

      doReset();
      idle(500);
      checkOutput("idle_complete", 256'(complete), 256'd0);

      bitVec = '0;
      bitVec[255:254] = 2'b11;
      for (int k = 0; k < 128; k++) applyStimulus(bitVec[255 - 2 * k -: 2], 1'b0);
      idle(1);
      readCheck("bitorder", 0, 0, {4'hC, 252'd0}, b_col_out);

      doReset();
      loadAll(1'b0, 1'b0, 8192);
      readCheck("full_r5c3", 5, 3, {32{8'h05}}, {32{8'hF3}});
      readCheck("full_r31c20", 31, 20, {32{8'h1F}}, {32{8'h14}});

      for (int k = 0; k < 300; k++) applyStimulus(2'b01, 1'b0);
      idle(1);
      readCheck("overrun", 0, 31, aRow(0, 1'b0), bCol(31, 1'b0));
      checkOutput("overrun_complete", 256'(complete), 256'd1);

      doReset();
      gapCtr = 0;
      loadAll(1'b0, 1'b1, 8192);
      checkAll("gaps", 1'b0);

      doReset();
      for (int k = 0; k < 4000; k++) applyStimulus(2'b10, 1'b0);
      doReset();
      loadAll(1'b1, 1'b0, 8192);
      checkAll("reload", 1'b1);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
